circ_regfile: RTL and testbench
===============================

Name: circ_regfile

Overview:
Parametrised successor to the single-cycle DSP register file. It is a DEPTH x DATA_W register array with two asynchronous read ports and a direct-addressed write port. It adds a circular "push" write port that makes the array double as a sample delay line for FIR/convolution loops: reads can be direct or relative to the newest sample. It sits in the register-read stage of the single-cycle datapath and is written on the clock edge at end of instruction.

Parameters:
DATA_W, 32, data word width in bits
DEPTH, 32, number of registers; power of two, 2..256
ADDR_W, 5, address width; must equal log2(DEPTH)

Ports:
clock  input  1  sole clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
RegWrite  input  1  direct write enable
WriteReg  input  ADDR_W  direct write address
WriteData  input  DATA_W  direct write data
push  input  1  circular write enable: store at head, advance head
push_data  input  DATA_W  circular write data
circ_mode  input  1  0 = direct read addressing, 1 = head-relative read addressing
ReadReg1  input  ADDR_W  read address or offset, port 1
ReadReg2  input  ADDR_W  read address or offset, port 2
ReadData1  output  DATA_W  read data, port 1
ReadData2  output  DATA_W  read data, port 2
head  output  ADDR_W  next circular write slot
count  output  ADDR_W+1  number of valid pushed samples, saturates at DEPTH
full  output  1  high when count == DEPTH

Behaviour:
- Reset, when reset=1 at a clock edge:
  - all DEPTH words <= 0, head <= 0, count <= 0.
  - reset overrides RegWrite and push in the same cycle.
- Reads are combinational; there is no read latency.
  - Physical address when circ_mode=0: ReadRegN.
  - Physical address when circ_mode=1: (head - 1 - ReadRegN) mod DEPTH, using ADDR_W-bit wrap arithmetic. Offset 0 is the newest pushed sample; offset DEPTH-1 is the oldest.
  - circ_mode applies to both read ports; it does not affect WriteReg.
- Direct write: RegWrite=1 at an edge sets mem[WriteReg] <= WriteData. No effect on head or count.
- Push: push=1 at an edge does the following:
  - mem[head] <= push_data.
  - head <= head+1, wrapping DEPTH-1 -> 0.
  - count <= min(count+1, DEPTH).
  - Once full, each push overwrites the oldest sample. count stays at DEPTH and full stays 1.
- Simultaneous RegWrite and push:
  - Different addresses: both writes take effect.
  - WriteReg == head: push_data wins, and head/count still advance.
- Without the optional feature, reads in a write cycle return the pre-edge value. The new value is visible after the edge.
- count and full track pushes only. Direct writes never change them.
- Outputs after reset: ReadData1/2 = 0 for any address or mode, head=0, count=0, full=0.
- With count=0 and circ_mode=1, reads return the reset contents (0). No error flag.

Optional Feature:
- Macro: CIRC_RF_BYPASS_EN.
- When defined, read ports forward same-cycle write data if the resolved physical read address matches a write this cycle.
  - Push data takes precedence over RegWrite data, matching the write priority.
  - In circ_mode, the comparison uses the pre-edge head.
  - reset=1 suppresses forwarding.
- When undefined, there is no forwarding logic and reads always show stored array contents.

Test Plan:
- Reset, then read all 32 addresses in both modes -> every ReadData = 0; head=0, count=0, full=0.
- Direct write: RegWrite=1, WriteReg=7, WriteData=26502; next cycle ReadReg1=7, circ_mode=0 -> ReadData1=26502; count stays 0.
- Push 3 samples 903, 7258, 10307; circ_mode=1, ReadReg1=0, ReadReg2=2 -> ReadData1=10307, ReadData2=903; head=3, count=3.
- Push 34 samples with values 1..34 (DEPTH=32) -> head=2, count=32, full=1; circ offset 0 = 34, offset 31 = 3, direct address 1 = 34.
- With head=5, assert RegWrite with WriteReg=5, WriteData=111 and push=1 with push_data=222 -> mem[5]=222, head=6; with bypass enabled, the same-cycle circ read at offset -1 equivalent (direct ReadReg1=5) returns 222.
- Mid-stream reset with push=1 and RegWrite=1 asserted -> next cycle all reads 0, head=0, count=0; following push of -5307 reads back at circ offset 0.

Source files
------------

// File: rtl/circ_regfile.sv
// DEPTH x DATA_W register file with direct and circular (push) write ports and
// direct/head-relative async reads. Define CIRC_RF_BYPASS_EN for same-cycle write forwarding.
module circ_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              circ_mode,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [ADDR_W-1:0] head,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2;

  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    if (push) begin
      // DEPTH is a power of two, so the natural ADDR_W wrap is the ring wrap
      head_d = head_q + ADDR_W'(1);
      if (count_q != FULL_CNT) begin
        count_d = count_q + (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      count_q <= '0;
    end else begin
      if (RegWrite) begin
        mem_q[WriteReg] <= WriteData;
      end
      // Later assignment wins: push data overrides a direct write to the same slot
      if (push) begin
        mem_q[head_q] <= push_data;
      end
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    rd_addr1 = ReadReg1;
    rd_addr2 = ReadReg2;
    if (circ_mode) begin
      rd_addr1 = head_q - ADDR_W'(1) - ReadReg1;
      rd_addr2 = head_q - ADDR_W'(1) - ReadReg2;
    end
  end

`ifdef CIRC_RF_BYPASS_EN
  always_comb begin
    ReadData1 = mem_q[rd_addr1];
    ReadData2 = mem_q[rd_addr2];
    if (!reset) begin
      if (push && (rd_addr1 == head_q)) begin
        ReadData1 = push_data;
      end else if (RegWrite && (rd_addr1 == WriteReg)) begin
        ReadData1 = WriteData;
      end
      if (push && (rd_addr2 == head_q)) begin
        ReadData2 = push_data;
      end else if (RegWrite && (rd_addr2 == WriteReg)) begin
        ReadData2 = WriteData;
      end
    end
  end
`else
  assign ReadData1 = mem_q[rd_addr1];
  assign ReadData2 = mem_q[rd_addr2];
`endif

  assign head  = head_q;
  assign count = count_q;
  assign full  = (count_q == FULL_CNT);

endmodule

// File: tb/tb_circ_regfile.sv
// Scoreboard bench for circ_regfile: stimulus queues expected outputs from an
// array-based reference model, a monitor process pops and compares them.
module tb_circ_regfile;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clock = 1'b0;
  logic              reset, RegWrite, push, circ_mode;
  logic [ADDR_W-1:0] WriteReg, ReadReg1, ReadReg2;
  logic [DATA_W-1:0] WriteData, push_data;
  logic [DATA_W-1:0] ReadData1, ReadData2;
  logic [ADDR_W-1:0] head;
  logic [ADDR_W:0]   count;
  logic              full;

  always #5 clock = ~clock;

  circ_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .push(push), .push_data(push_data),
    .circ_mode(circ_mode), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .head(head),
    .count(count), .full(full)
  );

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } item_t;

  item_t sbq[$];
  event  chk_ev;
  int    n_vec  = 0;
  int    n_miss = 0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_head;
  int                m_count;

  function automatic int phys(input logic cm, input int r);
    if (cm) return (((m_head - 1 - r) % DEPTH) + DEPTH) % DEPTH;
    return r;
  endfunction

  // Value the read port should show for physical slot a this cycle
  function automatic logic [31:0] model_read(input int a);
    logic [DATA_W-1:0] nm [DEPTH];
    nm = m_mem;
`ifdef CIRC_RF_BYPASS_EN
    if (!reset) begin
      if (RegWrite) nm[int'(WriteReg)] = WriteData;
      if (push)     nm[m_head] = push_data;
    end
`endif
    return nm[a];
  endfunction

  task automatic expect_v(input string name, input int kind, input logic [31:0] v);
    item_t it;
    it.name = name;
    it.kind = kind;
    it.exp  = v;
    sbq.push_back(it);
  endtask

  task automatic drive(input logic rst, input logic rw, input int wr, input logic [31:0] wd,
                       input logic p, input logic [31:0] pd, input logic cm,
                       input int r1, input int r2);
    @(negedge clock);
    reset     = rst;
    RegWrite  = rw;
    WriteReg  = ADDR_W'(wr);
    WriteData = wd;
    push      = p;
    push_data = pd;
    circ_mode = cm;
    ReadReg1  = ADDR_W'(r1);
    ReadReg2  = ADDR_W'(r2);
    #1;
    expect_v("rd1",   0, model_read(phys(cm, r1 % DEPTH)));
    expect_v("rd2",   1, model_read(phys(cm, r2 % DEPTH)));
    expect_v("head",  2, 32'(m_head));
    expect_v("count", 3, 32'(m_count));
    expect_v("full",  4, {31'd0, m_count == DEPTH});
  endtask

  task automatic tick();
    -> chk_ev;
    #1;
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_head  = 0;
      m_count = 0;
    end else begin
      if (RegWrite) m_mem[int'(WriteReg)] = WriteData;
      if (push) begin
        m_mem[m_head] = push_data;
        m_head  = (m_head + 1) % DEPTH;
        m_count = (m_count + 1 > DEPTH) ? DEPTH : m_count + 1;
      end
    end
  endtask

  task automatic do_push(input logic [31:0] v);
    drive(0, 0, 0, 0, 1, v, 0, 0, 0);
    tick();
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin : monitor
    item_t       it;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sbq.size() > 0) begin
        it = sbq.pop_front();
        case (it.kind)
          0:       act = ReadData1;
          1:       act = ReadData2;
          2:       act = 32'(head);
          3:       act = 32'(count);
          default: act = {31'd0, full};
        endcase
        n_vec++;
        if (act !== it.exp) begin
          n_miss++;
          $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                   it.name, act, act, it.exp, it.exp, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] neg_v;
    // Bring the array out of X before any checking
    reset = 1; RegWrite = 0; WriteReg = '0; WriteData = '0; push = 0;
    push_data = '0; circ_mode = 0; ReadReg1 = '0; ReadReg2 = '0;
    @(posedge clock);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_head = 0; m_count = 0;
    do_reset();

    // Every address in both modes reads zero after reset
    for (int cm = 0; cm < 2; cm++) begin
      for (int a = 0; a < DEPTH; a++) begin
        drive(0, 0, 0, 0, 0, 0, cm[0], a, DEPTH - 1 - a);
        expect_v("rst_rd1", 0, 32'd0);
        expect_v("rst_rd2", 1, 32'd0);
        tick();
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_v("rst_head", 2, 32'd0);
    expect_v("rst_count", 3, 32'd0);
    expect_v("rst_full", 4, 32'd0);
    tick();

    // Direct write then read back
    drive(0, 1, 7, 26502, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 7, 0);
    expect_v("dir_rd1", 0, 32'd26502);
    expect_v("dir_count", 3, 32'd0);
    tick();

    // Three pushes, head-relative reads
    do_push(903); do_push(7258); do_push(10307);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 2);
    expect_v("circ_new", 0, 32'd10307);
    expect_v("circ_old", 1, 32'd903);
    expect_v("circ_head", 2, 32'd3);
    expect_v("circ_count", 3, 32'd3);
    tick();

    // Overfill the ring
    do_reset();
    for (int v = 1; v <= 34; v++) do_push(32'(v));
    drive(0, 0, 0, 0, 0, 0, 1, 0, 31);
    expect_v("wrap_off0", 0, 32'd34);
    expect_v("wrap_off31", 1, 32'd3);
    expect_v("wrap_head", 2, 32'd2);
    expect_v("wrap_count", 3, 32'd32);
    expect_v("wrap_full", 4, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
    expect_v("wrap_dir1", 0, 32'd34);
    tick();

    // Direct write and push colliding on the head slot
    do_reset();
    for (int v = 1; v <= 5; v++) do_push(32'(v * 10));
    drive(0, 1, 5, 111, 1, 222, 0, 5, 4);
`ifdef CIRC_RF_BYPASS_EN
    expect_v("coll_fwd", 0, 32'd222);
`else
    expect_v("coll_pre", 0, 32'd0);
`endif
    expect_v("coll_head_pre", 2, 32'd5);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 5, 0);
    expect_v("coll_mem5", 0, 32'd222);
    expect_v("coll_head", 2, 32'd6);
    expect_v("coll_count", 3, 32'd6);
    tick();

    // Reset overrides same-cycle writes
    drive(1, 1, 9, 32'hDEAD_BEEF, 1, 32'hCAFE_F00D, 0, 9, 6);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 9, 6);
    expect_v("mrst_rd1", 0, 32'd0);
    expect_v("mrst_rd2", 1, 32'd0);
    expect_v("mrst_head", 2, 32'd0);
    expect_v("mrst_count", 3, 32'd0);
    tick();
    neg_v = -32'sd5307;
    do_push(neg_v);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    expect_v("mrst_push", 0, neg_v);
    tick();

    // Randomised traffic against the model
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(63) == 0), $urandom_range(1), $urandom_range(DEPTH - 1), $urandom,
            ($urandom_range(2) != 0), $urandom, $urandom_range(1),
            $urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1));
      tick();
    end

    #2;
    if (sbq.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
